wb_cmd_master: RTL

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_master_pkg.sv | 13 +
 rtl/wb_timeout_ctr.sv | 28 ++
 rtl/wb_cmd_master.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RESP
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam logic [31:0] ERR_DATA        = 32'h0;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count would reach the limit.
module wb_timeout_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'h0;
    end else if (clear) begin
      count <= 16'h0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Flagged one count early so the master drops stb on the edge at which
  // the count hits the limit, giving exactly 'limit' strobe cycles.
  assign expired = enable && (({1'b0, count} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master: one command in, one bus
// cycle out, one response back, with a timeout and stray-ack detection.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        stray_ack
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        ack_done;
  logic        to_done;
  logic        ctr_clear;
  logic        ctr_enable;
  logic        ctr_expired;
  logic        active;

  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic [31:0] rsp_dat_q;
  logic        rsp_err_q;
  logic        stray_q;

  wb_timeout_ctr u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .limit   (TIMEOUT_LIMIT),
    .expired (ctr_expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    ack_done   = 1'b0;
    to_done    = 1'b0;
    ctr_clear  = 1'b0;
    ctr_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          ctr_clear  = 1'b1;
          state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (wbm_ack_i) begin
          ack_done   = 1'b1;
          state_next = ST_RESP;
        end else begin
          ctr_enable = 1'b1;
          if (ctr_expired) begin
            to_done    = 1'b1;
            state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      we_q      <= 1'b0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      sel_q     <= 4'h0;
      rsp_dat_q <= 32'h0;
      rsp_err_q <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q  <= cmd_we;
        adr_q <= cmd_adr & ~32'h3;
        dat_q <= cmd_dat;
        sel_q <= cmd_sel;
      end
      if (ack_done) begin
        rsp_dat_q <= we_q ? 32'h0 : wbm_dat_i;
        rsp_err_q <= 1'b0;
      end else if (to_done) begin
        rsp_dat_q <= ERR_DATA;
        rsp_err_q <= 1'b1;
      end
      if (wbm_ack_i && (state != ST_ACTIVE)) begin
        stray_q <= 1'b1;
      end
    end
  end

  // Bus outputs are forced to zero whenever no cycle is in flight.
  assign active    = (state == ST_ACTIVE);
  assign wbm_cyc_o = active;
  assign wbm_stb_o = active;
  assign wbm_we_o  = active & we_q;
  assign wbm_adr_o = active ? adr_q : 32'h0;
  assign wbm_dat_o = active ? dat_q : 32'h0;
  assign wbm_sel_o = active ? sel_q : 4'h0;

  assign rsp_valid = (state == ST_RESP);
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign stray_ack = stray_q;

endmodule
